// File: rtl/decode_pkg.sv
// Shared encodings for the decode stage: ALU operations, immediate formats,
// next-PC selection, load/store width, FSM states and the control bundle.
package decode_pkg;

    // 19 ALU operations (10 base, LUI pass-through, 8 RV32M) need 5 bits.
    localparam int unsigned ALUOP_W = 5;
    // Divide countdown width; holds DIV_CYCLES-2 for DIV_CYCLES up to 32.
    localparam int unsigned CNT_W   = 5;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [ALUOP_W-1:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_AND    = 5'd2,
        ALU_OR     = 5'd3,
        ALU_XOR    = 5'd4,
        ALU_SLT    = 5'd5,
        ALU_SLTU   = 5'd6,
        ALU_SLL    = 5'd7,
        ALU_SRL    = 5'd8,
        ALU_SRA    = 5'd9,
        ALU_PASSB  = 5'd10,
        ALU_MUL    = 5'd11,
        ALU_MULH   = 5'd12,
        ALU_MULHSU = 5'd13,
        ALU_MULHU  = 5'd14,
        ALU_DIV    = 5'd15,
        ALU_DIVU   = 5'd16,
        ALU_REM    = 5'd17,
        ALU_REMU   = 5'd18
    } alu_op_e;

    // Branches are resolved from the ALU result: taken on zero or non-zero.
    typedef enum logic [2:0] {
        PC_NEXT  = 3'd0,
        PC_JAL   = 3'd1,
        PC_JALR  = 3'd2,
        PC_BR_Z  = 3'd3,
        PC_BR_NZ = 3'd4
    } pc_src_e;

    typedef enum logic [1:0] {
        RES_ALU   = 2'd0,
        RES_MEM   = 2'd1,
        RES_PC4   = 2'd2,
        RES_PCIMM = 2'd3
    } res_src_e;

    typedef enum logic [2:0] {
        IMM_I  = 3'd0,
        IMM_S  = 3'd1,
        IMM_B  = 3'd2,
        IMM_U  = 3'd3,
        IMM_J  = 3'd4,
        IMM_SH = 3'd5
    } imm_src_e;

    // Values match the load/store funct3 field.
    typedef enum logic [2:0] {
        B_MODE  = 3'd0,
        H_MODE  = 3'd1,
        W_MODE  = 3'd2,
        BU_MODE = 3'd4,
        HU_MODE = 3'd5
    } ls_mode_e;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_DIV_WAIT = 1'b1
    } state_e;

    typedef struct packed {
        pc_src_e  pc_src;
        res_src_e result_src;
        logic     mem_write;
        alu_op_e  alu_ctrl;
        logic     alu_src;
        imm_src_e imm_src;
        logic     reg_write;
        ls_mode_e ls_mode;
    } ctrl_t;

    // Bundle carried whenever nothing valid is presented to execute.
    function automatic ctrl_t nop_ctrl();
        ctrl_t c;
        c.pc_src     = PC_NEXT;
        c.result_src = RES_ALU;
        c.mem_write  = 1'b0;
        c.alu_ctrl   = ALU_ADD;
        c.alu_src    = 1'b0;
        c.imm_src    = IMM_I;
        c.reg_write  = 1'b0;
        c.ls_mode    = W_MODE;
        return c;
    endfunction

endpackage

// File: rtl/decode_comb.sv
// Pure combinational RV32I + RV32M decoder.
// Ports:
//   i_instr   - 32-bit instruction
//   o_ctrl    - unregistered control bundle (NOP bundle when illegal)
//   o_illegal - encoding not recognised
//   o_is_div  - legal DIV/DIVU/REM/REMU needing the multi-cycle path
module decode_comb
    import decode_pkg::*;
(
    input  logic [31:0] i_instr,
    output ctrl_t       o_ctrl,
    output logic        o_illegal,
    output logic        o_is_div
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    logic       w_bad;
    logic       w_div;
    logic       w_unused;

    assign w_opcode = i_instr[6:0];
    assign w_funct3 = i_instr[14:12];
    assign w_funct7 = i_instr[31:25];
    // Register and shamt fields do not affect control.
    assign w_unused = ^{i_instr[24:15], i_instr[11:7]};

    // Field decode; any unrecognised field collapses to the NOP bundle.
    always_comb begin
        o_ctrl = nop_ctrl();
        w_bad  = 1'b0;
        w_div  = 1'b0;
        case (w_opcode)
            OP_R: begin
                o_ctrl.reg_write = 1'b1;
                case (w_funct7)
                    7'h00: begin
                        case (w_funct3)
                            3'd0:    o_ctrl.alu_ctrl = ALU_ADD;
                            3'd1:    o_ctrl.alu_ctrl = ALU_SLL;
                            3'd2:    o_ctrl.alu_ctrl = ALU_SLT;
                            3'd3:    o_ctrl.alu_ctrl = ALU_SLTU;
                            3'd4:    o_ctrl.alu_ctrl = ALU_XOR;
                            3'd5:    o_ctrl.alu_ctrl = ALU_SRL;
                            3'd6:    o_ctrl.alu_ctrl = ALU_OR;
                            default: o_ctrl.alu_ctrl = ALU_AND;
                        endcase
                    end
                    7'h20: begin
                        case (w_funct3)
                            3'd0:    o_ctrl.alu_ctrl = ALU_SUB;
                            3'd5:    o_ctrl.alu_ctrl = ALU_SRA;
                            default: w_bad = 1'b1;
                        endcase
                    end
                    7'h01: begin
                        w_div = w_funct3[2];
                        case (w_funct3)
                            3'd0:    o_ctrl.alu_ctrl = ALU_MUL;
                            3'd1:    o_ctrl.alu_ctrl = ALU_MULH;
                            3'd2:    o_ctrl.alu_ctrl = ALU_MULHSU;
                            3'd3:    o_ctrl.alu_ctrl = ALU_MULHU;
                            3'd4:    o_ctrl.alu_ctrl = ALU_DIV;
                            3'd5:    o_ctrl.alu_ctrl = ALU_DIVU;
                            3'd6:    o_ctrl.alu_ctrl = ALU_REM;
                            default: o_ctrl.alu_ctrl = ALU_REMU;
                        endcase
                    end
                    default: w_bad = 1'b1;
                endcase
            end
            OP_IMM: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.imm_src   = IMM_I;
                case (w_funct3)
                    3'd0: o_ctrl.alu_ctrl = ALU_ADD;
                    3'd2: o_ctrl.alu_ctrl = ALU_SLT;
                    3'd3: o_ctrl.alu_ctrl = ALU_SLTU;
                    3'd4: o_ctrl.alu_ctrl = ALU_XOR;
                    3'd6: o_ctrl.alu_ctrl = ALU_OR;
                    3'd7: o_ctrl.alu_ctrl = ALU_AND;
                    3'd1: begin
                        o_ctrl.imm_src  = IMM_SH;
                        o_ctrl.alu_ctrl = ALU_SLL;
                        if (w_funct7 != 7'h00) w_bad = 1'b1;
                    end
                    default: begin
                        o_ctrl.imm_src = IMM_SH;
                        if (w_funct7 == 7'h00)      o_ctrl.alu_ctrl = ALU_SRL;
                        else if (w_funct7 == 7'h20) o_ctrl.alu_ctrl = ALU_SRA;
                        else                        w_bad = 1'b1;
                    end
                endcase
            end
            OP_LOAD: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.alu_src    = 1'b1;
                o_ctrl.imm_src    = IMM_I;
                o_ctrl.result_src = RES_MEM;
                o_ctrl.ls_mode    = ls_mode_e'(w_funct3);
                if (w_funct3 == 3'd3 || w_funct3 == 3'd6 || w_funct3 == 3'd7) w_bad = 1'b1;
            end
            OP_STORE: begin
                o_ctrl.mem_write = 1'b1;
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.imm_src   = IMM_S;
                o_ctrl.ls_mode   = ls_mode_e'(w_funct3);
                if (w_funct3[2] || w_funct3 == 3'd3) w_bad = 1'b1;
            end
            OP_BRANCH: begin
                o_ctrl.imm_src = IMM_B;
                case (w_funct3)
                    3'd0: begin o_ctrl.alu_ctrl = ALU_SUB;  o_ctrl.pc_src = PC_BR_Z;  end
                    3'd1: begin o_ctrl.alu_ctrl = ALU_SUB;  o_ctrl.pc_src = PC_BR_NZ; end
                    3'd4: begin o_ctrl.alu_ctrl = ALU_SLT;  o_ctrl.pc_src = PC_BR_NZ; end
                    3'd5: begin o_ctrl.alu_ctrl = ALU_SLT;  o_ctrl.pc_src = PC_BR_Z;  end
                    3'd6: begin o_ctrl.alu_ctrl = ALU_SLTU; o_ctrl.pc_src = PC_BR_NZ; end
                    3'd7: begin o_ctrl.alu_ctrl = ALU_SLTU; o_ctrl.pc_src = PC_BR_Z;  end
                    default: w_bad = 1'b1;
                endcase
            end
            OP_JAL: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.result_src = RES_PC4;
                o_ctrl.imm_src    = IMM_J;
                o_ctrl.pc_src     = PC_JAL;
            end
            OP_JALR: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.result_src = RES_PC4;
                o_ctrl.alu_src    = 1'b1;
                o_ctrl.imm_src    = IMM_I;
                o_ctrl.pc_src     = PC_JALR;
                if (w_funct3 != 3'd0) w_bad = 1'b1;
            end
            OP_LUI: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.imm_src   = IMM_U;
                o_ctrl.alu_ctrl  = ALU_PASSB;
            end
            OP_AUIPC: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.alu_src    = 1'b1;
                o_ctrl.imm_src    = IMM_U;
                o_ctrl.result_src = RES_PCIMM;
            end
            default: w_bad = 1'b1;
        endcase

        if (w_bad) o_ctrl = nop_ctrl();
        o_illegal = w_bad;
        o_is_div  = w_div & ~w_bad;
    end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage with valid/ready handshake and a multi-cycle
// hold for divide/remainder operations.
// Ports:
//   clk, rst             - clock, asynchronous active-high reset
//   instr, in_valid      - instruction from fetch
//   in_ready             - stage accepts instr this cycle (combinational)
//   flush                - discard held / in-flight instruction
//   out_valid, out_ready - handshake toward execute
//   PCsrc .. LS_mode     - registered control bundle
//   illegal              - registered bundle is an unrecognised encoding
//   busy                 - divide countdown in progress
module decode_stage
    import decode_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DIV_CYCLES = 4,
    parameter int unsigned ALUCTRL_W  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] instr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2:0]            PCsrc,
    output logic [1:0]            ResultSrc,
    output logic                  MemWrite,
    output logic [ALUCTRL_W-1:0]  ALUControl,
    output logic                  ALUsrc,
    output logic [2:0]            ImmSrc,
    output logic                  RegWrite,
    output logic [2:0]            LS_mode,
    output logic                  illegal,
    output logic                  busy
);

    localparam logic             DIV_MULTI = (DIV_CYCLES > 1);
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(DIV_CYCLES - 32'd2);

    state_e           r_state, w_state_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    ctrl_t            r_ctrl, w_ctrl_next;
    ctrl_t            r_pend, w_pend_next;
    logic             r_illegal, w_illegal_next;
    logic             r_valid, w_valid_next;

    logic [31:0]      w_instr;
    ctrl_t            w_dec_ctrl;
    logic             w_dec_illegal;
    logic             w_dec_is_div;
    logic             w_capture;

    assign w_instr = instr[31:0];

    decode_comb u_decode_comb (
        .i_instr   (w_instr),
        .o_ctrl    (w_dec_ctrl),
        .o_illegal (w_dec_illegal),
        .o_is_div  (w_dec_is_div)
    );

    assign in_ready  = ~rst & ~flush & (r_state == ST_IDLE) & (~r_valid | out_ready);
    assign w_capture = in_valid & in_ready;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_ctrl    <= nop_ctrl();
            r_pend    <= nop_ctrl();
            r_illegal <= 1'b0;
            r_valid   <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_ctrl    <= w_ctrl_next;
            r_pend    <= w_pend_next;
            r_illegal <= w_illegal_next;
            r_valid   <= w_valid_next;
        end
    end

    // Next state: capture, divide countdown, consumption and flush
    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_ctrl_next    = r_ctrl;
        w_pend_next    = r_pend;
        w_illegal_next = r_illegal;
        w_valid_next   = r_valid;

        if (flush) begin
            w_state_next   = ST_IDLE;
            w_cnt_next     = '0;
            w_ctrl_next    = nop_ctrl();
            w_pend_next    = nop_ctrl();
            w_illegal_next = 1'b0;
            w_valid_next   = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_capture) begin
                        if (w_dec_is_div && DIV_MULTI) begin
                            // Park the divide bundle; execute sees NOP until done.
                            w_state_next   = ST_DIV_WAIT;
                            w_cnt_next     = CNT_LOAD;
                            w_pend_next    = w_dec_ctrl;
                            w_ctrl_next    = nop_ctrl();
                            w_illegal_next = 1'b0;
                            w_valid_next   = 1'b0;
                        end else begin
                            w_ctrl_next    = w_dec_ctrl;
                            w_illegal_next = w_dec_illegal;
                            w_valid_next   = 1'b1;
                        end
                    end else if (out_ready) begin
                        w_ctrl_next    = nop_ctrl();
                        w_illegal_next = 1'b0;
                        w_valid_next   = 1'b0;
                    end
                end
                ST_DIV_WAIT: begin
                    if (r_cnt == '0) begin
                        w_state_next = ST_IDLE;
                        w_ctrl_next  = r_pend;
                        w_pend_next  = nop_ctrl();
                        w_valid_next = 1'b1;
                    end else begin
                        w_cnt_next = r_cnt - CNT_W'(1);
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    assign out_valid  = r_valid;
    assign illegal    = r_illegal;
    assign busy       = (r_state == ST_DIV_WAIT);
    assign PCsrc      = r_ctrl.pc_src;
    assign ResultSrc  = r_ctrl.result_src;
    assign MemWrite   = r_ctrl.mem_write;
    assign ALUControl = ALUCTRL_W'(r_ctrl.alu_ctrl);
    assign ALUsrc     = r_ctrl.alu_src;
    assign ImmSrc     = r_ctrl.imm_src;
    assign RegWrite   = r_ctrl.reg_write;
    assign LS_mode    = r_ctrl.ls_mode;

endmodule
